// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: valid/ready handshaked register with optional 2-entry skid,
// synchronous flush, bubble-masked control outputs and a saturating stall counter.
module ex_mem_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  read_data2,
    input  logic [XLEN-1:0]  result,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  inst_addr,
    input  logic             zero,
    input  logic             branch,
    input  logic             mem_read,
    input  logic             mem_to_reg,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic [REG_W-1:0] reg_id_w,
    input  logic [REG_W-1:0] tag1,
    input  logic [REG_W-1:0] tag2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  read_data2_o,
    output logic [XLEN-1:0]  result_o,
    output logic [XLEN-1:0]  branch_pc,
    output logic             zero_o,
    output logic             branch_o,
    output logic             mem_read_o,
    output logic             mem_to_reg_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic             branch_taken_o,
    output logic [REG_W-1:0] reg_id_wo,
    output logic [REG_W-1:0] tag1_o,
    output logic [REG_W-1:0] tag2_o,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  res;
        logic [XLEN-1:0]  bpc;
        logic             z;
        logic             br;
        logic             mr;
        logic             m2r;
        logic             mw;
        logic             rw;
        logic [REG_W-1:0] rid;
        logic [REG_W-1:0] t1;
        logic [REG_W-1:0] t2;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_next;
    entry_t main_q, skid_q, in_entry;
    logic   in_fire, out_fire;
    logic   load_main_in, load_main_skid, load_skid;

    always_comb begin
        in_entry.rd2 = read_data2;
        in_entry.res = result;
        in_entry.bpc = inst_addr + imm;
        in_entry.z   = zero;
        in_entry.br  = branch;
        in_entry.mr  = mem_read;
        in_entry.m2r = mem_to_reg;
        in_entry.mw  = mem_write;
        in_entry.rw  = reg_write;
        in_entry.rid = reg_id_w;
        in_entry.t1  = tag1;
        in_entry.t2  = tag2;
    end

    // Skid mode decodes in_ready from state only, so out_ready never reaches it.
    always_comb begin
        out_valid = (state != EMPTY);
        if (SKID_EN != 0) in_ready = (state != FULL);
        else              in_ready = !out_valid || out_ready;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Data fields hold their last value while invalid; control fields become a bubble.
    always_comb begin
        read_data2_o   = main_q.rd2;
        result_o       = main_q.res;
        branch_pc      = main_q.bpc;
        zero_o         = main_q.z;
        reg_id_wo      = main_q.rid;
        tag1_o         = main_q.t1;
        tag2_o         = main_q.t2;
        branch_o       = main_q.br  && out_valid;
        mem_read_o     = main_q.mr  && out_valid;
        mem_to_reg_o   = main_q.m2r && out_valid;
        mem_write_o    = main_q.mw  && out_valid;
        reg_write_o    = main_q.rw  && out_valid;
        branch_taken_o = main_q.br  && main_q.z && out_valid;
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a skid instance (CNT_W=4) and a non-skid instance share stimulus
// and are checked against queue-based reference models.
module tb_ex_mem_stage;

    localparam int XL = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic [XL-1:0] rd2, res, bpc;
        logic z, br, mr, m2r, mw, rw;
        logic [RW-1:0] rid, t1, t2;
    } pl_t;

    typedef struct packed {
        logic v, rdy;
        logic [XL-1:0] rd2, res, bpc;
        logic z, br, mr, m2r, mw, rw, bt;
        logic [RW-1:0] rid, t1, t2;
    } view_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, ready_a = 1'b0, ready_b = 1'b0;
    logic [XL-1:0] read_data2 = '0, result = '0, imm = '0, inst_addr = '0;
    logic zero = 1'b0, branch = 1'b0, mem_read = 1'b0, mem_to_reg = 1'b0;
    logic mem_write = 1'b0, reg_write = 1'b0;
    logic [RW-1:0] reg_id_w = '0, tag1 = '0, tag2 = '0;

    logic in_ready_a, out_valid_a, zero_o_a, branch_o_a, mem_read_o_a, mem_to_reg_o_a;
    logic mem_write_o_a, reg_write_o_a, branch_taken_o_a;
    logic [XL-1:0] read_data2_o_a, result_o_a, branch_pc_a;
    logic [RW-1:0] reg_id_wo_a, tag1_o_a, tag2_o_a;
    logic [3:0] stall_cnt_a;

    logic in_ready_b, out_valid_b, zero_o_b, branch_o_b, mem_read_o_b, mem_to_reg_o_b;
    logic mem_write_o_b, reg_write_o_b, branch_taken_o_b;
    logic [XL-1:0] read_data2_o_b, result_o_b, branch_pc_b;
    logic [RW-1:0] reg_id_wo_b, tag1_o_b, tag2_o_b;
    logic [15:0] stall_cnt_b;

    ex_mem_stage #(.XLEN(XL), .REG_W(RW), .SKID_EN(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .read_data2(read_data2), .result(result), .imm(imm), .inst_addr(inst_addr),
        .zero(zero), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .reg_write(reg_write), .reg_id_w(reg_id_w),
        .tag1(tag1), .tag2(tag2), .out_valid(out_valid_a), .out_ready(ready_a),
        .read_data2_o(read_data2_o_a), .result_o(result_o_a), .branch_pc(branch_pc_a),
        .zero_o(zero_o_a), .branch_o(branch_o_a), .mem_read_o(mem_read_o_a),
        .mem_to_reg_o(mem_to_reg_o_a), .mem_write_o(mem_write_o_a),
        .reg_write_o(reg_write_o_a), .branch_taken_o(branch_taken_o_a),
        .reg_id_wo(reg_id_wo_a), .tag1_o(tag1_o_a), .tag2_o(tag2_o_a),
        .stall_cnt(stall_cnt_a)
    );

    ex_mem_stage #(.XLEN(XL), .REG_W(RW), .SKID_EN(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .read_data2(read_data2), .result(result), .imm(imm), .inst_addr(inst_addr),
        .zero(zero), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .reg_write(reg_write), .reg_id_w(reg_id_w),
        .tag1(tag1), .tag2(tag2), .out_valid(out_valid_b), .out_ready(ready_b),
        .read_data2_o(read_data2_o_b), .result_o(result_o_b), .branch_pc(branch_pc_b),
        .zero_o(zero_o_b), .branch_o(branch_o_b), .mem_read_o(mem_read_o_b),
        .mem_to_reg_o(mem_to_reg_o_b), .mem_write_o(mem_write_o_b),
        .reg_write_o(reg_write_o_b), .branch_taken_o(branch_taken_o_b),
        .reg_id_wo(reg_id_wo_b), .tag1_o(tag1_o_b), .tag2_o(tag2_o_b),
        .stall_cnt(stall_cnt_b)
    );

    view_t obs_a, obs_b;
    assign obs_a = {out_valid_a, in_ready_a, read_data2_o_a, result_o_a, branch_pc_a,
                    zero_o_a, branch_o_a, mem_read_o_a, mem_to_reg_o_a, mem_write_o_a,
                    reg_write_o_a, branch_taken_o_a, reg_id_wo_a, tag1_o_a, tag2_o_a};
    assign obs_b = {out_valid_b, in_ready_b, read_data2_o_b, result_o_b, branch_pc_b,
                    zero_o_b, branch_o_b, mem_read_o_b, mem_to_reg_o_b, mem_write_o_b,
                    reg_write_o_b, branch_taken_o_b, reg_id_wo_b, tag1_o_b, tag2_o_b};

    // Reference model: a bounded FIFO per instance plus the last payload shown.
    pl_t qa[$], qb[$];
    pl_t sh_a, sh_b;
    int unsigned cnt_a, cnt_b;

    always @(posedge clk) begin : model
        pl_t p;
        bit fi, fo;
        p.rd2 = read_data2; p.res = result; p.bpc = inst_addr + imm;
        p.z = zero; p.br = branch; p.mr = mem_read; p.m2r = mem_to_reg;
        p.mw = mem_write; p.rw = reg_write; p.rid = reg_id_w; p.t1 = tag1; p.t2 = tag2;
        if (rst) begin
            qa.delete(); qb.delete();
            sh_a = '0; sh_b = '0; cnt_a = 0; cnt_b = 0;
        end else begin
            fi = in_valid && (qa.size() < 2);
            fo = (qa.size() > 0) && ready_a;
            if (qa.size() > 0 && !ready_a && cnt_a < 15) cnt_a++;
            if (flush) qa.delete();
            else begin
                if (fo) void'(qa.pop_front());
                if (fi) qa.push_back(p);
            end
            if (qa.size() > 0) sh_a = qa[0];

            fi = in_valid && (qb.size() == 0 || ready_b);
            fo = (qb.size() > 0) && ready_b;
            if (qb.size() > 0 && !ready_b && cnt_b < 65535) cnt_b++;
            if (flush) qb.delete();
            else begin
                if (fo) void'(qb.pop_front());
                if (fi) qb.push_back(p);
            end
            if (qb.size() > 0) sh_b = qb[0];
        end
    end

    function automatic view_t mk_view(bit v, bit r, pl_t s);
        view_t w;
        w.v = v; w.rdy = r; w.rd2 = s.rd2; w.res = s.res; w.bpc = s.bpc; w.z = s.z;
        w.br = s.br & v; w.mr = s.mr & v; w.m2r = s.m2r & v; w.mw = s.mw & v;
        w.rw = s.rw & v; w.bt = s.br & s.z & v;
        w.rid = s.rid; w.t1 = s.t1; w.t2 = s.t2;
        return w;
    endfunction

    function automatic view_t view_a();
        return mk_view(qa.size() > 0, qa.size() < 2, sh_a);
    endfunction

    function automatic view_t view_b();
        return mk_view(qb.size() > 0, qb.size() == 0 || ready_b, sh_b);
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_payload();
        read_data2 = $urandom; result = $urandom; imm = $urandom; inst_addr = $urandom;
        zero = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1));
        mem_read = 1'($urandom_range(0, 1)); mem_to_reg = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1)); reg_write = 1'($urandom_range(0, 1));
        reg_id_w = RW'($urandom); tag1 = RW'($urandom); tag2 = RW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        view_t z0;
        z0 = '0; z0.rdy = 1'b1;
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        rand_payload();
        step(); step();
        n_cmp++; if (obs_a !== z0) begin n_bad++; $display("FAIL reset_a: got %h expected %h", obs_a, z0); end
        n_cmp++; if (obs_b !== z0) begin n_bad++; $display("FAIL reset_b: got %h expected %h", obs_b, z0); end
        n_cmp++; if (stall_cnt_a !== 4'd0) begin n_bad++; $display("FAIL reset_cnt_a: got %0d expected 0", stall_cnt_a); end
        n_cmp++; if (stall_cnt_b !== 16'd0) begin n_bad++; $display("FAIL reset_cnt_b: got %0d expected 0", stall_cnt_b); end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        ready_a = 1'b1; ready_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_payload(); result = XL'(i); in_valid = 1'b1;
            step();
            n_cmp++; if (obs_a !== view_a()) begin n_bad++; $display("FAIL stream_a: got %h expected %h", obs_a, view_a()); end
            n_cmp++; if (obs_b !== view_b()) begin n_bad++; $display("FAIL stream_b: got %h expected %h", obs_b, view_b()); end
            n_cmp++; if (out_valid_a !== 1'b1 || result_o_a !== XL'(i)) begin
                n_bad++; $display("FAIL stream_result: got v=%b %0d expected v=1 %0d", out_valid_a, result_o_a, i);
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got %b expected 0", out_valid_a); end
        n_cmp++; if (stall_cnt_a !== 4'd0 || stall_cnt_b !== 16'd0) begin
            n_bad++; $display("FAIL stream_cnt: got %0d/%0d expected 0/0", stall_cnt_a, stall_cnt_b);
        end
    endtask

    task automatic test_branch_target();
        do_reset();
        ready_a = 1'b1; ready_b = 1'b1;
        rand_payload(); inst_addr = 32'h0000_1000; imm = 32'hFFFF_FFF8;
        branch = 1'b1; zero = 1'b1; in_valid = 1'b1;
        step();
        n_cmp++; if (branch_pc_a !== 32'h0000_0FF8 || branch_pc_b !== 32'h0000_0FF8) begin
            n_bad++; $display("FAIL branch_pc: got %h/%h expected 00000ff8", branch_pc_a, branch_pc_b);
        end
        n_cmp++; if (branch_taken_o_a !== 1'b1) begin n_bad++; $display("FAIL branch_taken: got %b expected 1", branch_taken_o_a); end
        inst_addr = 32'hFFFF_FFFC; imm = 32'h0000_0008;
        step();
        n_cmp++; if (branch_pc_a !== 32'h0000_0004) begin n_bad++; $display("FAIL branch_wrap: got %h expected 00000004", branch_pc_a); end
        n_cmp++; if (obs_a !== view_a()) begin n_bad++; $display("FAIL branch_view: got %h expected %h", obs_a, view_a()); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [XL-1:0] ord [3];
        int idx, dlv;
        bit acc;
        ord[0] = 32'd100; ord[1] = 32'd101; ord[2] = 32'd102;
        idx = 0; dlv = 0;
        do_reset();
        ready_a = 1'b0; ready_b = 1'b1;
        rand_payload(); result = ord[0]; in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            acc = in_valid && (qa.size() < 2);
            if (ready_a && out_valid_a) begin
                n_cmp++;
                if (dlv >= 3) begin n_bad++; $display("FAIL bp_extra: got %0d expected no delivery", result_o_a); end
                else if (result_o_a !== ord[dlv]) begin n_bad++; $display("FAIL bp_order: got %0d expected %0d", result_o_a, ord[dlv]); end
                dlv++;
            end
            step();
            n_cmp++; if (obs_a !== view_a()) begin n_bad++; $display("FAIL bp_view: got %h expected %h", obs_a, view_a()); end
            if (acc) begin
                idx++;
                if (idx == 2) begin
                    n_cmp++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b expected 0", in_ready_a); end
                end
                if (idx < 3) begin rand_payload(); result = ord[idx]; end
                else in_valid = 1'b0;
            end
            if (c == 5) ready_a = 1'b1;
        end
        n_cmp++; if (dlv !== 3 || idx !== 3) begin n_bad++; $display("FAIL bp_count: got %0d/%0d expected 3/3", dlv, idx); end
        n_cmp++; if (stall_cnt_a !== 4'd5) begin n_bad++; $display("FAIL bp_stall: got %0d expected 5", stall_cnt_a); end
    endtask

    task automatic test_flush();
        do_reset();
        ready_a = 1'b0; ready_b = 1'b1;
        rand_payload(); mem_write = 1'b1; reg_write = 1'b1; result = 32'd200; in_valid = 1'b1;
        step();
        rand_payload(); mem_write = 1'b1; reg_write = 1'b1; result = 32'd201;
        step();
        rand_payload(); mem_write = 1'b1; reg_write = 1'b1; result = 32'd202; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid_a !== 1'b0 || mem_write_o_a !== 1'b0 || reg_write_o_a !== 1'b0 || in_ready_a !== 1'b1) begin
            n_bad++; $display("FAIL flush_full: got v=%b mw=%b rw=%b rdy=%b expected 0 0 0 1",
                              out_valid_a, mem_write_o_a, reg_write_o_a, in_ready_a);
        end
        n_cmp++; if (out_valid_b !== 1'b0) begin n_bad++; $display("FAIL flush_b: got %b expected 0", out_valid_b); end
        n_cmp++; if (obs_a !== view_a()) begin n_bad++; $display("FAIL flush_view: got %h expected %h", obs_a, view_a()); end
        ready_a = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
                n_bad++; $display("FAIL flush_ghost: got %b/%b expected 0/0", out_valid_a, out_valid_b);
            end
        end
        ready_a = 1'b0;
        rand_payload(); result = 32'd210; in_valid = 1'b1;
        step();
        rand_payload(); result = 32'd212; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL flush_one: got %b expected 0", out_valid_a); end
            step();
        end
        n_cmp++; if (stall_cnt_a !== 4'(cnt_a)) begin n_bad++; $display("FAIL flush_cnt: got %0d expected %0d", stall_cnt_a, cnt_a); end
    endtask

    task automatic test_no_skid();
        int nres, ndl;
        bit acc;
        nres = 0; ndl = 0;
        do_reset();
        ready_a = 1'b1;
        rand_payload(); result = '0; in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            ready_b = (c % 2 == 0);
            #1;
            n_cmp++; if (obs_b !== view_b()) begin n_bad++; $display("FAIL noskid_view: got %h expected %h", obs_b, view_b()); end
            if (out_valid_b && ready_b) begin
                n_cmp++; if (result_o_b !== XL'(ndl)) begin n_bad++; $display("FAIL noskid_order: got %0d expected %0d", result_o_b, ndl); end
                ndl++;
            end
            acc = in_valid && (qb.size() == 0 || ready_b);
            step();
            if (acc) begin nres++; rand_payload(); result = XL'(nres); end
        end
        in_valid = 1'b0; ready_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (out_valid_b && ready_b) begin
                n_cmp++; if (result_o_b !== XL'(ndl)) begin n_bad++; $display("FAIL noskid_order: got %0d expected %0d", result_o_b, ndl); end
                ndl++;
            end
            step();
        end
        n_cmp++; if (ndl !== nres) begin n_bad++; $display("FAIL noskid_count: got %0d expected %0d", ndl, nres); end
    endtask

    task automatic test_saturation();
        do_reset();
        ready_a = 1'b0; ready_b = 1'b0;
        rand_payload(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) step();
        n_cmp++; if (stall_cnt_a !== 4'd15) begin n_bad++; $display("FAIL sat_a: got %0d expected 15", stall_cnt_a); end
        n_cmp++; if (stall_cnt_b !== 16'd20) begin n_bad++; $display("FAIL sat_b: got %0d expected 20", stall_cnt_b); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (stall_cnt_a !== 4'd0) begin n_bad++; $display("FAIL sat_rst: got %0d expected 0", stall_cnt_a); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            rand_payload();
            in_valid = 1'($urandom_range(0, 3) != 0);
            ready_a  = 1'($urandom_range(0, 2) != 0);
            ready_b  = 1'($urandom_range(0, 2) != 0);
            flush    = 1'($urandom_range(0, 15) == 0);
            step();
            n_cmp++; if (obs_a !== view_a()) begin n_bad++; $display("FAIL rand_a: got %h expected %h", obs_a, view_a()); end
            n_cmp++; if (obs_b !== view_b()) begin n_bad++; $display("FAIL rand_b: got %h expected %h", obs_b, view_b()); end
            n_cmp++; if (stall_cnt_a !== 4'(cnt_a) || stall_cnt_b !== 16'(cnt_b)) begin
                n_bad++; $display("FAIL rand_cnt: got %0d/%0d expected %0d/%0d", stall_cnt_a, stall_cnt_b, cnt_a, cnt_b);
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_branch_target();
        test_backpressure();
        test_flush();
        test_no_skid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
